// File: rtl/fetch_pc.sv
// Fetch program counter with decode-stage PC/prediction registers.
// Optional 8-entry direct-mapped BTB compiled in with `define FETCH_BTB_EN.
module fetch_pc (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall_fetch,
  input  logic        i_stall_decode,
  input  logic        i_flush_decode,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_br_update,
  input  logic [31:0] i_br_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_decode,
  output logic [31:0] o_pc4_decode,
  output logic        o_pred_taken_decode,
  output logic [31:0] o_pred_target_decode
);

  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_next;
  logic [31:0] pc_next;

  assign pc_plus4 = o_pc + 32'd4;

`ifdef FETCH_BTB_EN
  logic [7:0]  btb_valid;
  logic [26:0] btb_tag    [8];
  logic [31:0] btb_target [8];
  logic [1:0]  btb_ctr    [8];
  logic [2:0]  rd_idx;
  logic [2:0]  wr_idx;
  logic        wr_hit;

  assign rd_idx = o_pc[4:2];
  assign wr_idx = i_br_pc[4:2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == i_br_pc[31:5]);

  // Lookup reads the arrays as they were before this edge's update.
  always_comb begin
    pred_taken = btb_valid[rd_idx] && (btb_tag[rd_idx] == o_pc[31:5]) &&
                 btb_ctr[rd_idx][1];
    pred_next  = pred_taken ? btb_target[rd_idx] : pc_plus4;
  end

  // Only the valid bits need reset; data fields are qualified by valid.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      btb_valid <= '0;
    end else if (i_br_update && !wr_hit && i_br_taken) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_br_update) begin
      if (wr_hit) begin
        if (i_br_taken) begin
          btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'd3) ? 2'd3 : btb_ctr[wr_idx] + 2'd1;
          btb_target[wr_idx] <= {i_br_target[31:2], 2'b00};
        end else begin
          btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'd0) ? 2'd0 : btb_ctr[wr_idx] - 2'd1;
        end
      end else if (i_br_taken) begin
        btb_tag[wr_idx]    <= i_br_pc[31:5];
        btb_target[wr_idx] <= {i_br_target[31:2], 2'b00};
        btb_ctr[wr_idx]    <= 2'd2;
      end
    end
  end

  logic unused_btb;
  assign unused_btb = ^{i_br_pc[1:0], i_br_target[1:0]};
`else
  always_comb begin
    pred_taken = 1'b0;
    pred_next  = pc_plus4;
  end

  logic unused_btb;
  assign unused_btb = ^{i_br_update, i_br_pc, i_br_taken, i_br_target};
`endif

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^i_redirect_pc[1:0];

  // Redirect beats fetch stall; target is forced word-aligned.
  always_comb begin
    pc_next = pred_next;
    if (i_redirect) begin
      pc_next = {i_redirect_pc[31:2], 2'b00};
    end else if (i_stall_fetch) begin
      pc_next = o_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pc <= 32'd0;
    end else begin
      o_pc <= pc_next;
    end
  end

  // Loaded on the same edge the instruction memory latches memory[o_pc].
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pc_decode          <= 32'd0;
      o_pc4_decode         <= 32'd0;
      o_pred_taken_decode  <= 1'b0;
      o_pred_target_decode <= 32'd0;
    end else if (i_stall_decode) begin
      o_pc_decode          <= o_pc_decode;
      o_pc4_decode         <= o_pc4_decode;
      o_pred_taken_decode  <= o_pred_taken_decode;
      o_pred_target_decode <= o_pred_target_decode;
    end else if (i_flush_decode) begin
      o_pc_decode          <= 32'd0;
      o_pc4_decode         <= 32'd0;
      o_pred_taken_decode  <= 1'b0;
      o_pred_target_decode <= 32'd0;
    end else begin
      o_pc_decode          <= o_pc;
      o_pc4_decode         <= pc_plus4;
      o_pred_taken_decode  <= pred_taken;
      o_pred_target_decode <= pred_next;
    end
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have i_clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have i_reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have i_stall_fetch  input  1  hold fetch PC.
REQ-004 SHALL have i_stall_decode  input  1  hold decode-stage registers; same signal that drives the instruction memory stall.
REQ-005 SHALL have i_flush_decode  input  1  zero decode-stage registers; same signal that drives the instruction memory flush.
REQ-006 SHALL have i_redirect  input  1  execute-stage redirect (mispredict or jump).
REQ-007 SHALL have i_redirect_pc  input  32  redirect target.
REQ-008 SHALL have i_br_update  input  1  resolved branch or jump valid in execute.
REQ-009 SHALL have i_br_pc  input  32  PC of the resolved branch.
REQ-010 SHALL have i_br_taken  input  1  resolved direction.
REQ-011 SHALL have i_br_target  input  32  resolved target.
REQ-012 SHALL have o_pc  output  32  registered fetch PC, drives instruction memory address.
REQ-013 SHALL have o_pc_decode  output  32  PC paired with the decode-stage instruction.
REQ-014 SHALL have o_pc4_decode  output  32  o_pc_decode + 4.
REQ-015 SHALL have o_pred_taken_decode  output  1  fetch predicted taken.
REQ-016 SHALL have o_pred_target_decode  output  32  predicted next PC used at fetch.

Function
REQ-017 Next fetch PC SHALL be chosen per edge by priority:
- i_redirect: {i_redirect_pc[31:2],2'b00}
- else i_stall_fetch: hold
- else predicted next PC (REQ-021).
REQ-018 i_redirect SHALL override i_stall_fetch in the same cycle.
REQ-019 Decode-stage registers (o_pc_decode, o_pc4_decode, o_pred_*) SHALL update by priority:
- i_stall_decode: hold
- else i_flush_decode: all zero
- else capture current o_pc, o_pc+4, prediction, target.
REQ-020 Decode-stage registers SHALL be loaded on the same edge that the instruction memory registers memory[o_pc], so PC and instruction stay paired with zero skew.
REQ-021 Predicted next PC SHALL be o_pc+4 (32-bit, wrap at 0xFFFFFFFC to 0x0) unless the BTB predicts taken (REQ-029).
REQ-022 o_pred_target_decode SHALL equal the predicted next PC computed for the captured o_pc, even when fetch stalls.
REQ-023 PC arithmetic SHALL be 32-bit unsigned; bits [1:0] of o_pc SHALL always be 0.

Reset
REQ-024 While i_reset is low: o_pc=0, o_pc_decode=0, o_pc4_decode=0, o_pred_taken_decode=0, o_pred_target_decode=0, all BTB valid bits=0.
REQ-025 Reset asserted mid-operation SHALL take effect immediately, independent of stall, flush or redirect.
REQ-026 First edge after reset release SHALL advance o_pc to 0x4, unless stalled or redirected.

Configuration
REQ-027 Macro FETCH_BTB_EN SHALL compile in an 8-entry direct-mapped BTB: index pc[4:2], tag pc[31:5], 32-bit target, 2-bit saturating counter, valid bit.
REQ-028 Without FETCH_BTB_EN: no BTB storage, i_br_* ignored, next PC always o_pc+4, o_pred_taken_decode constant 0.
REQ-029 With FETCH_BTB_EN: predict taken when the entry is valid, the tag matches and counter>=2; predicted next PC = stored target.
REQ-030 BTB update on i_br_update, entry indexed by i_br_pc:
- hit: counter +1 if taken, -1 if not taken, saturating 0..3; target rewritten if taken
- miss and taken: allocate with valid=1, tag, target, counter=2
- miss and not taken: no change.
REQ-031 BTB writes SHALL be registered; a lookup in the same cycle as an update to the same index SHALL see pre-update contents.

Verification
REQ-032 Reset release with no stall: o_pc = 0x4, 0x8, 0xC on successive edges; o_pc_decode lags o_pc by one edge.
REQ-033 i_stall_fetch high 2 cycles at o_pc=0x10: o_pc holds 0x10, then advances to 0x14.
REQ-034 i_redirect=1, i_redirect_pc=0x103, i_stall_fetch=1 in the same cycle: o_pc=0x100 next edge.
REQ-035 i_stall_decode=1 and i_flush_decode=1 together: decode registers hold; i_flush_decode=1 alone: decode registers all 0.
REQ-036 FETCH_BTB_EN defined, update pc=0x20 taken, target=0x80; later fetch at 0x20: next o_pc=0x80, o_pred_taken_decode=1. After two not-taken updates: next o_pc=0x24.
REQ-037 FETCH_BTB_EN undefined, same stimulus as REQ-036: next o_pc=0x24, o_pred_taken_decode=0.
